forwarding_hazard_scoreboard: RTL and testbench
===============================================

Name: forwarding_hazard_scoreboard

Overview:
- Parametrised successor to the two-operand, two-stage forwarding logic. Generalises to NUM_SRC source operands and NUM_STAGES forwarding stages.
- Adds a per-register scoreboard for variable-latency writers (MUL/DIV, uncached loads) and a load-use/WAW interlock that generates stall.
- Sits beside the decode/ID stage. Consumes decoded source addresses and the destination tags of downstream stages. Produces operand-mux selects and a stall to the pipeline control.

Parameters:
- REG_AW, 5, register address width; register 0 is hard-wired zero.
- NUM_SRC, 2, number of source operands checked per cycle.
- NUM_STAGES, 2, forwarding stages after EX. Stage 1 is the youngest (EX/MEM), stage NUM_STAGES the oldest.
- SEL_W, $clog2(NUM_STAGES+1), width of one select field.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- src_addr  in  NUM_SRC*REG_AW  source register addresses of the instruction in ID
- src_used  in  NUM_SRC  operand i actually read
- stage_rd  in  NUM_STAGES*REG_AW  destination register per stage
- stage_we  in  NUM_STAGES  stage writes a register
- stage_late  in  NUM_STAGES  stage result not yet available (load before data return)
- issue_valid  in  1  instruction in ID advances this cycle, absent stall
- issue_rd  in  REG_AW  its destination
- issue_long  in  1  destination is written by the variable-latency unit
- done_valid  in  1  variable-latency unit writes back this cycle
- done_rd  in  REG_AW  its destination
- flush  in  1  squash the ID instruction
- fwd_sel  out  NUM_SRC*SEL_W  per operand: 0 = regfile, k = stage k
- stall  out  1  hold ID and insert a bubble
- pending  out  2**REG_AW  scoreboard bitmap
- stall_cycles  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset (rst_n low at a clk edge): pending = 0, stall_cycles = 0. Combinational outputs follow their inputs. fwd_sel is 0 and stall is 0 when no match exists.
- Forwarding (combinational): for each operand i with src_used[i] and address != 0, choose the lowest k with stage_we[k] and stage_rd[k] == addr. Youngest wins. No match gives 0. An operand with src_used[i] = 0 or address 0 always gets select 0.
- Load-use hazard: the selected stage k has stage_late[k] = 1. Asserts stall.
- Scoreboard hazard: pending[addr] = 1 and no stage matches. Asserts stall. A stage match overrides pending, because the stage holds the newer value.
- WAW hazard: issue_valid with issue_long = 1, and either pending[issue_rd] = 1 or any stage_we[k] with stage_rd[k] == issue_rd. Asserts stall.
- stall = OR of all hazards, gated to 0 when flush = 1.
- Scoreboard update on a clk edge:
  - Set: issue_valid & issue_long & !stall & !flush & issue_rd != 0 sets pending[issue_rd].
  - Clear: done_valid clears pending[done_rd].
  - Simultaneous set and clear of the same register: set wins.
  - done_valid for a register that is not pending: ignored, no error.
  - done_rd == 0: ignored.
- Completion-cycle bypass: the result of done_valid is written to the regfile that cycle. An operand matching done_rd in the same cycle is not stalled by pending; the regfile write-through supplies it.
- flush does not clear pending; long operations already launched still complete.
- stall_cycles increments on every cycle where stall = 1 and saturates at all-ones.
- Reset mid-operation clears the scoreboard. Any later done_valid is then ignored per the not-pending rule.

Decomposition:
- Shared core package holds:
  - FWD_SEL_RF = 0.
  - Opcode constants used by decode to derive stage_late and issue_long (LOAD = 7'b0000011, MULDIV funct7 = 7'b0000001).
  - REG_AW default.
- One sub-module, fwd_match_select, instantiated NUM_SRC times. Inputs: one address, stage_rd, stage_we, stage_late. Outputs: select, late_hit, any_hit.
- The scoreboard register and counter stay in the top module.

Test Plan:
- src_addr = {x2, x1}, stage1 rd = x1 we = 1, stage2 rd = x1 we = 1, late = 0 -> fwd_sel[0] = 1 (youngest), fwd_sel[1] = 0, stall = 0.
- Stage1 rd = x5 we = 1 late = 1, src0 = x5 -> stall = 1. Next cycle, with the load moved to stage2 and late = 0 -> fwd_sel[0] = 2, stall = 0.
- Issue long to x7 at cycle 0, consumer reads x7 at cycles 1–9, done_valid x7 at cycle 10 -> pending[7] = 1 for cycles 1–10, stall = 1 for cycles 1–9, stall = 0 at cycle 10, pending[7] = 0 at cycle 11, stall_cycles = 9.
- src = x0 with stage1 rd = x0 we = 1 -> fwd_sel = 0, stall = 0. Issue long with rd = x0 -> pending stays 0.
- pending[3] = 1, then a second long issue to x3 -> stall = 1 (WAW). Same-cycle done_valid x3 and issue x3 without stall -> pending[3] stays 1.
- Stall condition present with flush = 1 -> stall = 0, no pending bit set. Drive rst_n = 0 for one edge while pending = 0x0000_0088 -> pending = 0, stall_cycles = 0 at the next cycle.

Source files
------------

// File: rtl/forwarding_hazard_scoreboard_pkg.sv
//==============================================================================
// Module   : forwarding_hazard_scoreboard_pkg
// Brief    : Shared constants and decode helpers for the forwarding/hazard unit.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package forwarding_hazard_scoreboard_pkg;

   localparam int         REG_AW_DEFAULT = 5;
   localparam int         FWD_SEL_RF     = 0;
   localparam logic [6:0] OPC_LOAD       = 7'b0000011;
   localparam logic [6:0] OPC_OP         = 7'b0110011;
   localparam logic [6:0] FUNCT7_MULDIV  = 7'b0000001;

   // Decode uses these to derive stage_late and issue_long.
   function automatic logic is_load(input logic [6:0] opcode);
      return opcode == OPC_LOAD;
   endfunction

   function automatic logic is_muldiv(input logic [6:0] opcode, input logic [6:0] funct7);
      return (opcode == OPC_OP) && (funct7 == FUNCT7_MULDIV);
   endfunction

endpackage

`default_nettype wire

// File: rtl/forwarding_hazard_scoreboard_fwd_match_select.sv
//==============================================================================
// Module   : fwd_match_select
// Brief    : Youngest-stage match for one source address; reports late/any hit.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module fwd_match_select
   import forwarding_hazard_scoreboard_pkg::*;
#(
   parameter int REG_AW     = REG_AW_DEFAULT,
   parameter int NUM_STAGES = 2,
   parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
   input  logic [REG_AW-1:0]            addr,
   input  logic [NUM_STAGES*REG_AW-1:0] stage_rd,
   input  logic [NUM_STAGES-1:0]        stage_we,
   input  logic [NUM_STAGES-1:0]        stage_late,
   output logic [SEL_W-1:0]             sel,
   output logic                         late_hit,
   output logic                         any_hit
);

   always_comb begin
      sel      = SEL_W'(FWD_SEL_RF);
      late_hit = 1'b0;
      any_hit  = 1'b0;
      // Walk oldest to youngest so the youngest match is the one left standing.
      if (addr != '0) begin
         for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (stage_we[k] && (stage_rd[k*REG_AW +: REG_AW] == addr)) begin
               sel      = SEL_W'(k + 1);
               late_hit = stage_late[k];
               any_hit  = 1'b1;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/forwarding_hazard_scoreboard.sv
//==============================================================================
// Module   : forwarding_hazard_scoreboard
// Brief    : Operand forwarding selects, long-latency scoreboard and stall logic.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module forwarding_hazard_scoreboard
   import forwarding_hazard_scoreboard_pkg::*;
#(
   parameter int REG_AW     = REG_AW_DEFAULT,
   parameter int NUM_SRC    = 2,
   parameter int NUM_STAGES = 2,
   parameter int SEL_W      = $clog2(NUM_STAGES + 1),
   parameter int CNT_W      = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_SRC*REG_AW-1:0]    src_addr,
   input  logic [NUM_SRC-1:0]           src_used,
   input  logic [NUM_STAGES*REG_AW-1:0] stage_rd,
   input  logic [NUM_STAGES-1:0]        stage_we,
   input  logic [NUM_STAGES-1:0]        stage_late,
   input  logic                         issue_valid,
   input  logic [REG_AW-1:0]            issue_rd,
   input  logic                         issue_long,
   input  logic                         done_valid,
   input  logic [REG_AW-1:0]            done_rd,
   input  logic                         flush,
   output logic [NUM_SRC*SEL_W-1:0]     fwd_sel,
   output logic                         stall,
   output logic [2**REG_AW-1:0]         pending,
   output logic [CNT_W-1:0]             stall_cycles
);

   logic [2**REG_AW-1:0] r_pending;
   logic [2**REG_AW-1:0] w_pending_nxt;
   logic [CNT_W-1:0]     r_stall_cycles;
   logic [NUM_SRC-1:0]   w_op_hazard;
   logic                 w_issue_stage_hit;
   logic                 w_waw;
   logic                 w_stall;
   logic                 w_set;

   for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [REG_AW-1:0] w_addr;
      logic [SEL_W-1:0]  w_sel;
      logic              w_late;
      logic              w_hit;

      assign w_addr = src_addr[gi*REG_AW +: REG_AW];

      fwd_match_select #(
         .REG_AW     (REG_AW),
         .NUM_STAGES (NUM_STAGES),
         .SEL_W      (SEL_W)
      ) u_match (
         .addr       (w_addr),
         .stage_rd   (stage_rd),
         .stage_we   (stage_we),
         .stage_late (stage_late),
         .sel        (w_sel),
         .late_hit   (w_late),
         .any_hit    (w_hit)
      );

      assign fwd_sel[gi*SEL_W +: SEL_W] = src_used[gi] ? w_sel : SEL_W'(FWD_SEL_RF);

      // A stage match carries the newer value; a same-cycle writeback is read through the regfile.
      assign w_op_hazard[gi] = src_used[gi] && (w_addr != '0) &&
                               (w_late || (!w_hit && r_pending[w_addr] &&
                                           !(done_valid && (done_rd == w_addr))));
   end

   always_comb begin
      w_issue_stage_hit = 1'b0;
      for (int k = 0; k < NUM_STAGES; k++) begin
         if (stage_we[k] && (stage_rd[k*REG_AW +: REG_AW] == issue_rd)) begin
            w_issue_stage_hit = 1'b1;
         end
      end
   end

   assign w_waw   = issue_valid && issue_long && (issue_rd != '0) &&
                    (r_pending[issue_rd] || w_issue_stage_hit);
   assign w_stall = ((|w_op_hazard) || w_waw) && !flush;
   assign w_set   = issue_valid && issue_long && !w_stall && !flush && (issue_rd != '0);

   // Set is applied after clear so a same-register collision leaves the bit set.
   always_comb begin
      w_pending_nxt = r_pending;
      if (done_valid && (done_rd != '0)) begin
         w_pending_nxt[done_rd] = 1'b0;
      end
      if (w_set) begin
         w_pending_nxt[issue_rd] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pending      <= '0;
         r_stall_cycles <= '0;
      end else begin
         r_pending <= w_pending_nxt;
         if (w_stall && (r_stall_cycles != {CNT_W{1'b1}})) begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
         end
      end
   end

   assign stall        = w_stall;
   assign pending      = r_pending;
   assign stall_cycles = r_stall_cycles;

endmodule

`default_nettype wire

// File: tb/tb_forwarding_hazard_scoreboard.sv
//==============================================================================
// Module   : tb_forwarding_hazard_scoreboard
// Brief    : Directed self-checking bench for forwarding_hazard_scoreboard.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_forwarding_hazard_scoreboard;

   localparam int REG_AW     = 5;
   localparam int NUM_SRC    = 2;
   localparam int NUM_STAGES = 2;
   localparam int SEL_W      = 2;
   localparam int CNT_W      = 16;

   logic                         clk = 1'b0;
   logic                         rst_n;
   logic [NUM_SRC*REG_AW-1:0]    src_addr;
   logic [NUM_SRC-1:0]           src_used;
   logic [NUM_STAGES*REG_AW-1:0] stage_rd;
   logic [NUM_STAGES-1:0]        stage_we;
   logic [NUM_STAGES-1:0]        stage_late;
   logic                         issue_valid;
   logic [REG_AW-1:0]            issue_rd;
   logic                         issue_long;
   logic                         done_valid;
   logic [REG_AW-1:0]            done_rd;
   logic                         flush;
   logic [NUM_SRC*SEL_W-1:0]     fwd_sel;
   logic                         stall;
   logic [2**REG_AW-1:0]         pending;
   logic [CNT_W-1:0]             stall_cycles;

   forwarding_hazard_scoreboard #(
      .REG_AW     (REG_AW),
      .NUM_SRC    (NUM_SRC),
      .NUM_STAGES (NUM_STAGES),
      .SEL_W      (SEL_W),
      .CNT_W      (CNT_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .src_addr     (src_addr),
      .src_used     (src_used),
      .stage_rd     (stage_rd),
      .stage_we     (stage_we),
      .stage_late   (stage_late),
      .issue_valid  (issue_valid),
      .issue_rd     (issue_rd),
      .issue_long   (issue_long),
      .done_valid   (done_valid),
      .done_rd      (done_rd),
      .flush        (flush),
      .fwd_sel      (fwd_sel),
      .stall        (stall),
      .pending      (pending),
      .stall_cycles (stall_cycles)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      int          kind;
      logic [31:0] v;
   } exp_t;

   exp_t q[$];
   int   npass = 0;
   int   ntotal = 0;
   int   m_cyc = 0;
   bit   m_stall = 1'b0;

   task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] observe(input int kind);
      case (kind)
         0:       return 32'(fwd_sel[1:0]);
         1:       return 32'(fwd_sel[3:2]);
         2:       return 32'(stall);
         3:       return pending;
         default: return 32'(stall_cycles);
      endcase
   endfunction

   // Push the expected outputs for the inputs just driven, then drain against the DUT.
   task automatic check(input string name, input int f0, input int f1, input bit st,
                        input logic [31:0] pend);
      exp_t e;
      q.push_back('{{name, ".fwd0"}, 0, 32'(f0)});
      q.push_back('{{name, ".fwd1"}, 1, 32'(f1)});
      q.push_back('{{name, ".stall"}, 2, 32'(st)});
      q.push_back('{{name, ".pending"}, 3, pend});
      q.push_back('{{name, ".stall_cycles"}, 4, 32'(m_cyc)});
      m_stall = st;
      #1;
      while (q.size() > 0) begin
         e = q.pop_front();
         compare(e.tag, observe(e.kind), e.v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (m_stall && rst_n) m_cyc++;
      @(negedge clk);
   endtask

   task automatic idle();
      src_addr    = '0;
      src_used    = '0;
      stage_rd    = '0;
      stage_we    = '0;
      stage_late  = '0;
      issue_valid = 1'b0;
      issue_rd    = '0;
      issue_long  = 1'b0;
      done_valid  = 1'b0;
      done_rd     = '0;
      flush       = 1'b0;
   endtask

   task automatic stg(input int k, input int rd, input bit we, input bit late);
      stage_rd[(k-1)*REG_AW +: REG_AW] = REG_AW'(rd);
      stage_we[k-1]   = we;
      stage_late[k-1] = late;
   endtask

   task automatic src(input int i, input int a, input bit used);
      src_addr[i*REG_AW +: REG_AW] = REG_AW'(a);
      src_used[i] = used;
   endtask

   task automatic issue(input int rd);
      issue_valid = 1'b1;
      issue_long  = 1'b1;
      issue_rd    = REG_AW'(rd);
   endtask

   task automatic done(input int rd);
      done_valid = 1'b1;
      done_rd    = REG_AW'(rd);
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset", 0, 0, 0, 32'h0);
      rst_n = 1'b1;

      // Forwarding priority, write-enable gating, src_used gating
      idle(); src(0, 1, 1); src(1, 2, 1); stg(1, 1, 1, 0); stg(2, 1, 1, 0);
      check("fwd_young", 1, 0, 0, 32'h0); step();
      idle(); src(0, 1, 1); src(1, 2, 1); stg(1, 2, 0, 0); stg(2, 2, 1, 0);
      check("fwd_old", 0, 2, 0, 32'h0); step();
      idle(); src(0, 1, 0); src(1, 2, 1); stg(1, 1, 1, 0);
      check("unused", 0, 0, 0, 32'h0); step();

      // Load-use then forward from stage 2
      idle(); src(0, 5, 1); stg(1, 5, 1, 1);
      check("loaduse", 1, 0, 1, 32'h0); step();
      idle(); src(0, 5, 1); stg(2, 5, 1, 0);
      check("load_moved", 2, 0, 0, 32'h0); step();

      // Long-latency writer to x7
      idle(); issue(7);
      check("lng_issue", 0, 0, 0, 32'h0); step();
      for (int c = 1; c <= 9; c++) begin
         idle(); src(0, 7, 1);
         check("lng_wait", 0, 0, 1, 32'h80); step();
      end
      idle(); src(0, 7, 1); done(7);
      check("lng_done", 0, 0, 0, 32'h80); step();
      idle(); src(0, 7, 1);
      check("lng_clear", 0, 0, 0, 32'h0); step();

      // Register zero
      idle(); src(0, 0, 1); stg(1, 0, 1, 0); issue(0);
      check("x0", 0, 0, 0, 32'h0); step();
      idle();
      check("x0_pend", 0, 0, 0, 32'h0); step();

      // WAW, stage override, set-wins, stray completion
      idle(); issue(3);
      check("waw_first", 0, 0, 0, 32'h0); step();
      check("waw_pend", 0, 0, 1, 32'h8); step();
      idle(); src(0, 3, 1); stg(1, 3, 1, 0);
      check("sb_override", 1, 0, 0, 32'h8); step();
      idle(); issue(4); stg(2, 4, 1, 0);
      check("waw_stage", 0, 0, 1, 32'h8); step();
      idle(); done(3);
      check("clr", 0, 0, 0, 32'h8); step();
      idle(); done(3); issue(3);
      check("set_wins_pre", 0, 0, 0, 32'h0); step();
      idle(); done(9);
      check("set_wins", 0, 0, 0, 32'h8); step();
      idle();
      check("done_np", 0, 0, 0, 32'h8); step();

      // Flush masks stall and blocks the scoreboard set
      idle(); src(0, 5, 1); stg(1, 5, 1, 1); issue(7); flush = 1'b1;
      check("flush", 1, 0, 0, 32'h8); step();
      idle();
      check("flush_nopend", 0, 0, 0, 32'h8); step();

      // Reset mid-operation
      idle(); issue(7);
      check("pre_rst", 0, 0, 0, 32'h8); step();
      idle();
      check("pend88", 0, 0, 0, 32'h88);
      rst_n = 1'b0;
      step();
      m_cyc = 0;
      check("rst_mid", 0, 0, 0, 32'h0);
      rst_n = 1'b1;
      done(7);
      check("late_done", 0, 0, 0, 32'h0); step();
      idle();
      check("after_done", 0, 0, 0, 32'h0);

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule

`default_nettype wire
